// File: rtl/fifo_ctrl_sync.sv
// fifo_ctrl_sync: synchronous FIFO controller for an external dual-port RAM
// (registered write, asynchronous read); FWFT output, occupancy and level flags.
module fifo_ctrl_sync #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int DEPTH_LOG = $clog2(DEPTH),
    parameter int AF_LEVEL  = DEPTH - 2,
    parameter int AE_LEVEL  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic                 ram_we,
    output logic [DEPTH_LOG-1:0] ram_addr_wr,
    output logic [WIDTH-1:0]     ram_data_wr,
    output logic [DEPTH_LOG-1:0] ram_addr_rd,
    input  logic [WIDTH-1:0]     ram_data_rd,
    output logic [DEPTH_LOG:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty
);
    logic [DEPTH_LOG-1:0] wr_ptr, rd_ptr;
    logic push, pop;

    function automatic logic [DEPTH_LOG-1:0] advance(input logic [DEPTH_LOG-1:0] p);
        return (p == DEPTH_LOG'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full         = count == (DEPTH_LOG+1)'(DEPTH);
    assign empty        = count == '0;
    assign almost_full  = count >= (DEPTH_LOG+1)'(AF_LEVEL);
    assign almost_empty = count <= (DEPTH_LOG+1)'(AE_LEVEL);
    assign s_ready      = !full && !flush;
    assign m_valid      = !empty && !flush;
    assign push         = s_valid && s_ready;
    assign pop          = m_valid && m_ready;
    assign ram_we       = push;
    assign ram_addr_wr  = wr_ptr;
    assign ram_data_wr  = s_data;
    assign ram_addr_rd  = rd_ptr;
    assign m_data       = ram_data_rd;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= advance(wr_ptr);
            if (pop) rd_ptr <= advance(rd_ptr);
            count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
        end
    end
endmodule

// File: tb/tb_fifo_ctrl_sync.sv
// tb_fifo_ctrl_sync: DEPTH=16 and DEPTH=12 controllers with bench RAMs, checked
// cycle by cycle against a reference model and a data scoreboard queue.
module tb_fifo_ctrl_sync;
    logic clk = 0;
    always #5 clk = ~clk;

    logic       rst_n, flush, s_valid, m_ready, sel;
    logic [7:0] s_data;

    logic       a_s_ready, a_m_valid, a_we, a_full, a_empty, a_af, a_ae;
    logic [7:0] a_m_data, a_wd, a_rd_data;
    logic [3:0] a_wa, a_ra;
    logic [4:0] a_count;
    logic       b_s_ready, b_m_valid, b_we, b_full, b_empty, b_af, b_ae;
    logic [7:0] b_m_data, b_wd, b_rd_data;
    logic [3:0] b_wa, b_ra;
    logic [4:0] b_count;
    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];

    fifo_ctrl_sync #(.WIDTH(8), .DEPTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .s_valid(s_valid), .s_ready(a_s_ready),
        .s_data(s_data), .m_valid(a_m_valid), .m_ready(m_ready), .m_data(a_m_data),
        .ram_we(a_we), .ram_addr_wr(a_wa), .ram_data_wr(a_wd), .ram_addr_rd(a_ra),
        .ram_data_rd(a_rd_data), .count(a_count), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae));

    fifo_ctrl_sync #(.WIDTH(8), .DEPTH(12)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .s_valid(s_valid), .s_ready(b_s_ready),
        .s_data(s_data), .m_valid(b_m_valid), .m_ready(m_ready), .m_data(b_m_data),
        .ram_we(b_we), .ram_addr_wr(b_wa), .ram_data_wr(b_wd), .ram_addr_rd(b_ra),
        .ram_data_rd(b_rd_data), .count(b_count), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae));

    always @(posedge clk) begin
        if (a_we) mem_a[a_wa] <= a_wd;
        if (b_we) mem_b[b_wa] <= b_wd;
    end
    assign a_rd_data = mem_a[a_ra];
    assign b_rd_data = mem_b[b_ra];

    int         checks = 0, errors = 0;
    int         cnt, wp, rp, dep;
    bit         known;
    logic [7:0] q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic rn, input logic fl, input logic v, input logic mr, input logic [7:0] d);
        logic acc, vld, pp;
        rst_n = rn; flush = fl; s_valid = v; m_ready = mr; s_data = d;
        #1;
        acc = v && cnt < dep && !fl;
        vld = cnt > 0 && !fl;
        pp  = vld && mr;
        if (known) begin
            check("count",        sel ? b_count   : a_count,   cnt);
            check("full",         sel ? b_full    : a_full,    cnt == dep);
            check("empty",        sel ? b_empty   : a_empty,   cnt == 0);
            check("almost_full",  sel ? b_af      : a_af,      cnt >= dep - 2);
            check("almost_empty", sel ? b_ae      : a_ae,      cnt <= 2);
            check("s_ready",      sel ? b_s_ready : a_s_ready, !fl && cnt < dep);
            check("m_valid",      sel ? b_m_valid : a_m_valid, vld);
            check("ram_we",       sel ? b_we      : a_we,      acc);
            if (acc) begin
                check("ram_addr_wr", sel ? b_wa : a_wa, wp);
                check("ram_data_wr", sel ? b_wd : a_wd, d);
            end
            if (vld) begin
                check("ram_addr_rd", sel ? b_ra : a_ra, rp);
                check("m_data", sel ? b_m_data : a_m_data, q[0]);
            end
        end
        @(posedge clk);
        if (!rn || fl) begin
            cnt = 0; wp = 0; rp = 0; q.delete();
            if (!rn) known = 1;
        end else begin
            if (acc) begin
                q.push_back(d);
                wp = (wp == dep - 1) ? 0 : wp + 1;
            end
            if (pp) begin
                void'(q.pop_front());
                rp = (rp == dep - 1) ? 0 : rp + 1;
            end
            cnt = cnt + int'(acc) - int'(pp);
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic v, mr;
        sel = 0; dep = 16; known = 0; cnt = 0; wp = 0; rp = 0;
        rst_n = 0; flush = 0; s_valid = 0; m_ready = 0; s_data = 0;
        @(negedge clk);
        cyc(0, 0, 0, 0, 0);
        // basic pushes, head word falls through
        cyc(1, 0, 1, 0, 8'h11);
        cyc(1, 0, 1, 0, 8'h22);
        cyc(1, 0, 1, 0, 8'h33);
        cyc(1, 0, 0, 0, 0);
        // fill to full, then further pushes are refused
        for (int i = 0; i < 13; i++) cyc(1, 0, 1, 0, 8'(8'h40 + i));
        cyc(1, 0, 1, 0, 8'hee);
        cyc(1, 0, 1, 0, 8'hef);
        // full with push and pop together: pop only, push next cycle
        cyc(1, 0, 1, 1, 8'hf0);
        cyc(1, 0, 1, 0, 8'hf1);
        // drain to 5, then stream with both sides active across the wrap
        for (int i = 0; i < 11; i++) cyc(1, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) cyc(1, 0, 1, 1, 8'($urandom));
        // flush with count=7 and s_valid high
        cyc(1, 0, 1, 0, 8'h70);
        cyc(1, 0, 1, 0, 8'h71);
        cyc(1, 1, 1, 1, 8'h77);
        cyc(1, 0, 0, 0, 0);
        // reset during streaming
        for (int i = 0; i < 6; i++) cyc(1, 0, 1, i[0], 8'(8'h80 + i));
        cyc(0, 0, 1, 1, 8'h99);
        cyc(1, 0, 0, 0, 0);
        // DEPTH=12 build: fill past capacity, then random traffic until 30 words pushed
        sel = 1; dep = 12; known = 0; cnt = 0; wp = 0; rp = 0; q.delete();
        cyc(0, 0, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 14; i++) begin
            if (cnt < dep) n++;
            cyc(1, 0, 1, 0, 8'(8'hb0 + i));
        end
        for (int i = 0; i < 300 && n < 30; i++) begin
            v  = $urandom_range(0, 3) != 0;
            mr = 1'($urandom_range(0, 1));
            if (v && cnt < dep) n++;
            cyc(1, 0, v, mr, 8'($urandom));
        end
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 1, 0);
        check("b_drained_empty", b_empty, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
